// File: rtl/riscv_pkg.sv
// Shared types for the multi-cycle RV32 sequencer: FSM states, the opcode
// subset it executes, and next-PC source encodings.
package riscv_pkg;

  typedef enum logic [2:0] {
    FETCH,
    IF_WAIT,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JAL    = 2'b10;

  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction- and data-memory req/ack handshakes between the sequencer
// (master) and the memory subsystem (slave).
interface instr_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/seq_perf_counters.sv
// Free-running cycle and retired-instruction counters; only elaborated when
// SEQ_PERF_CNT_EN is defined, so the default build carries no counter flops.
`ifdef SEQ_PERF_CNT_EN
module seq_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halted,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Both counters wrap naturally at 2^CNT_W.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (!halted) cycle_d   = cycle_q + CNT_W'(1);
    if (retire)  instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
`endif

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the RV32 datapath.
// Define SEQ_PERF_CNT_EN to build the cycle/instret performance counters.
module instr_sequencer
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic                alu_zero,
  instr_sequencer_if.master   mem,
  output logic                ir_write,
  output logic                mdr_write,
  output logic                reg_write,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic                retire,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Outputs are decoded from state and op_q; only the ack-qualified strobes
  // (and the branch pc_sel) see inputs combinationally.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    retire       = 1'b0;
    halted       = 1'b0;

    case (state_q)
      FETCH: begin
        if (run) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        op_d    = opcode;
        state_d = op_legal(opcode) ? EXEC : TRAP;
      end
      EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BRANCH: begin
            pc_write = 1'b1;
            retire   = 1'b1;
            pc_sel   = alu_zero ? PC_SEL_BRANCH : PC_SEL_PLUS4;
            state_d  = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (op_q == OP_STORE);
        if (mem.dmem_ack) begin
          if (op_q == OP_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end else begin
            mdr_write = 1'b1;
            state_d   = WB;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        pc_sel    = (op_q == OP_JAL) ? PC_SEL_JAL : PC_SEL_PLUS4;
        state_d   = FETCH;
      end
      TRAP: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  seq_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .halted     (halted),
    .retire     (retire),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-vector bench for instr_sequencer: latency, strobes, handshakes,
// trap, mid-fetch reset and (when built) the performance counters.
module tb_instr_sequencer;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst, run, alu_zero;
  logic [6:0] opcode;
  logic       ir_write, mdr_write, reg_write, pc_write, retire, halted;
  logic [1:0] pc_sel;
  logic [3:0] cycle_cnt, instret_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  instr_sequencer_if bus();

  instr_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem(bus), .ir_write(ir_write), .mdr_write(mdr_write),
    .reg_write(reg_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .retire(retire), .halted(halted), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int ir_c; int mdr_c; int reg_c; int pcw_c;
    int ret_n; int reg_n; int pcw_n; int mdr_n; int dreq_n; int dwe_n;
    logic [1:0] psel;
  } obs_t;

  task automatic clear_inputs();
    run = 1'b0; opcode = '0; alu_zero = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one instruction from a FETCH cycle, acting as both memories, and
  // records which cycle (1 = the FETCH cycle) each strobe appeared in.
  // opcode is corrupted after DECODE so EXEC must rely on the latched copy.
  // noise=1 holds the ack of any idle port high to exercise ack filtering.
  task automatic exec_instr(input logic [6:0] op, input int if_wait,
                            input int dm_wait, input logic az,
                            input logic noise, output obs_t o);
    int  ireq, dreq;
    bit  done;
    o = '{default: 0};
    ireq = 0; dreq = 0; done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      run      = (k == 1);
      opcode   = (o.ir_c != 0 && k > o.ir_c + 1) ? 7'h7f : op;
      alu_zero = az;
      bus.imem_ack = bus.imem_req ? (ireq >= if_wait) : noise;
      bus.dmem_ack = bus.dmem_req ? (dreq >= dm_wait) : noise;
      if (bus.imem_req) ireq++;
      if (bus.dmem_req) dreq++;
      #1;
      if (ir_write)  o.ir_c = k;
      if (mdr_write) begin o.mdr_n++; o.mdr_c = k; end
      if (reg_write) begin o.reg_n++; o.reg_c = k; end
      if (pc_write)  begin o.pcw_n++; o.pcw_c = k; o.psel = pc_sel; end
      if (bus.dmem_req) o.dreq_n++;
      if (bus.dmem_req && bus.dmem_we) o.dwe_n++;
      if (retire) begin o.ret_n++; o.cyc = k; done = 1; end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ir_write, mdr_write, reg_write, pc_write, retire, halted,
         bus.imem_req, bus.dmem_req, bus.dmem_we, pc_sel} !== 11'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b required all zero",
        {ir_write, mdr_write, reg_write, pc_write, retire, halted,
         bus.imem_req, bus.dmem_req, bus.dmem_we, pc_sel});
    end
    n_vec++;
    if ({cycle_cnt, instret_cnt} !== 8'h00) begin
      n_err++; $display("FAIL reset_counters: got %h required 00", {cycle_cnt, instret_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    obs_t o;
    exec_instr(OP_R, 0, 0, 1'b0, 1'b0, o);
    $display("rtype: cycles=%0d ir@%0d reg@%0d pc@%0d pc_sel=%b", o.cyc, o.ir_c, o.reg_c, o.pcw_c, o.psel);
    n_vec++; if (o.cyc !== 5) begin n_err++; $display("FAIL rtype_latency: got %0d required 5", o.cyc); end
    n_vec++; if (o.ir_c !== 2) begin n_err++; $display("FAIL rtype_ir_write: got cycle %0d required 2", o.ir_c); end
    n_vec++; if (o.reg_c !== 5 || o.pcw_c !== 5 || o.ret_n !== 1) begin
      n_err++; $display("FAIL rtype_wb: got reg@%0d pc@%0d retires=%0d required 5/5/1", o.reg_c, o.pcw_c, o.ret_n); end
    n_vec++; if (o.psel !== 2'b00 || o.dreq_n !== 0) begin
      n_err++; $display("FAIL rtype_pcsel: got pc_sel=%b dreq=%0d required 00/0", o.psel, o.dreq_n); end
    n_vec++; if (bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL rtype_idle: got imem_req=%b required 0", bus.imem_req); end
  endtask

  task automatic test_load_wait();
    obs_t o;
    exec_instr(OP_LOAD, 0, 3, 1'b0, 1'b0, o);
    $display("load wait3: cycles=%0d dreq=%0d dwe=%0d mdr@%0d reg@%0d", o.cyc, o.dreq_n, o.dwe_n, o.mdr_c, o.reg_c);
    n_vec++; if (o.cyc !== 9) begin n_err++; $display("FAIL load_latency: got %0d required 9", o.cyc); end
    n_vec++; if (o.dreq_n !== 4 || o.dwe_n !== 0) begin
      n_err++; $display("FAIL load_dmem_req: got req=%0d we=%0d required 4/0", o.dreq_n, o.dwe_n); end
    n_vec++; if (o.mdr_c !== 8 || o.reg_c !== 9 || o.mdr_n !== 1) begin
      n_err++; $display("FAIL load_strobes: got mdr@%0d reg@%0d n_mdr=%0d required 8/9/1", o.mdr_c, o.reg_c, o.mdr_n); end
  endtask

  task automatic test_branch();
    obs_t o;
    exec_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0, o);
    $display("beq taken: cycles=%0d pc@%0d pc_sel=%b regs=%0d", o.cyc, o.pcw_c, o.psel, o.reg_n);
    n_vec++; if (o.cyc !== 4 || o.pcw_c !== 4) begin
      n_err++; $display("FAIL beq_taken_latency: got %0d/pc@%0d required 4/4", o.cyc, o.pcw_c); end
    n_vec++; if (o.psel !== 2'b01 || o.reg_n !== 0) begin
      n_err++; $display("FAIL beq_taken_sel: got pc_sel=%b regs=%0d required 01/0", o.psel, o.reg_n); end
    exec_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0, o);
    $display("beq not taken: cycles=%0d pc_sel=%b regs=%0d", o.cyc, o.psel, o.reg_n);
    n_vec++; if (o.cyc !== 4 || o.psel !== 2'b00 || o.reg_n !== 0) begin
      n_err++; $display("FAIL beq_nt: got cycles=%0d pc_sel=%b regs=%0d required 4/00/0", o.cyc, o.psel, o.reg_n); end
  endtask

  task automatic test_jal_store();
    obs_t o;
    exec_instr(OP_JAL, 0, 0, 1'b0, 1'b0, o);
    $display("jal: cycles=%0d pc_sel=%b regs=%0d", o.cyc, o.psel, o.reg_n);
    n_vec++; if (o.cyc !== 5 || o.psel !== 2'b10 || o.reg_n !== 1) begin
      n_err++; $display("FAIL jal: got cycles=%0d pc_sel=%b regs=%0d required 5/10/1", o.cyc, o.psel, o.reg_n); end
    exec_instr(OP_STORE, 0, 0, 1'b0, 1'b0, o);
    $display("store: cycles=%0d dreq=%0d dwe=%0d regs=%0d pc_sel=%b", o.cyc, o.dreq_n, o.dwe_n, o.reg_n, o.psel);
    n_vec++; if (o.cyc !== 5 || o.pcw_c !== 5 || o.psel !== 2'b00) begin
      n_err++; $display("FAIL store_retire: got cycles=%0d pc@%0d pc_sel=%b required 5/5/00", o.cyc, o.pcw_c, o.psel); end
    n_vec++; if (o.dreq_n !== 1 || o.dwe_n !== 1 || o.reg_n !== 0 || o.mdr_n !== 0) begin
      n_err++; $display("FAIL store_dmem: got req=%0d we=%0d regs=%0d mdr=%0d required 1/1/0/0",
                        o.dreq_n, o.dwe_n, o.reg_n, o.mdr_n); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exec_instr(OP_IMM, 2, 0, 1'b0, 1'b1, o);
    $display("imm wait2 noisy: cycles=%0d ir@%0d", o.cyc, o.ir_c);
    n_vec++; if (o.cyc !== 7 || o.ir_c !== 4 || o.reg_c !== 7) begin
      n_err++; $display("FAIL imm_wait: got cycles=%0d ir@%0d reg@%0d required 7/4/7", o.cyc, o.ir_c, o.reg_c); end
    exec_instr(OP_LOAD, 0, 0, 1'b0, 1'b1, o);
    $display("load noisy: cycles=%0d mdr@%0d reg@%0d", o.cyc, o.mdr_c, o.reg_c);
    n_vec++; if (o.cyc !== 6 || o.mdr_c !== 5 || o.reg_c !== 6) begin
      n_err++; $display("FAIL load_zero_wait: got cycles=%0d mdr@%0d reg@%0d required 6/5/6", o.cyc, o.mdr_c, o.reg_c); end
    exec_instr(OP_STORE, 0, 1, 1'b0, 1'b1, o);
    $display("store wait1 noisy: cycles=%0d dwe=%0d", o.cyc, o.dwe_n);
    n_vec++; if (o.cyc !== 6 || o.dwe_n !== 2) begin
      n_err++; $display("FAIL store_wait: got cycles=%0d we=%0d required 6/2", o.cyc, o.dwe_n); end
  endtask

  task automatic test_trap();
    bit bad;
    run = 1'b1; opcode = 7'h7f;
    @(posedge clk); #1;
    run = 1'b0; bus.imem_ack = 1'b1; #1;
    n_vec++; if (ir_write !== 1'b1) begin n_err++; $display("FAIL trap_fetch: got ir_write=%b required 1", ir_write); end
    @(posedge clk); #1;
    bus.imem_ack = 1'b0; #1;
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL trap_decode: got halted=%b required 0", halted); end
    @(posedge clk); #1;
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL trap_halted: got halted=%b required 1", halted); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      run = 1'b1; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
      @(posedge clk); #1;
      if (bus.imem_req || bus.dmem_req || ir_write || retire || pc_write || !halted) bad = 1;
    end
    $display("trap hold: 20 cycles, disturbed=%0d", bad);
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL trap_frozen: got disturbed=%0d required 0", bad); end
    rst = 1'b1; clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (halted !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL trap_rst: got halted=%b imem_req=%b required 0/0", halted, bus.imem_req); end
    run = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL trap_refetch: got imem_req=%b required 1", bus.imem_req); end
    do_reset();
  endtask

  task automatic test_rst_mid_fetch();
    obs_t o;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL midrst_req: got imem_req=%b required 1", bus.imem_req); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_drop: got imem_req=%b required 0", bus.imem_req); end
    bus.imem_ack = 1'b1; #1;
    n_vec++; if (ir_write !== 1'b0) begin n_err++; $display("FAIL midrst_late_ack: got ir_write=%b required 0", ir_write); end
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b0 || ir_write !== 1'b0) begin
      n_err++; $display("FAIL midrst_idle: got imem_req=%b ir_write=%b required 0/0", bus.imem_req, ir_write); end
    exec_instr(OP_R, 0, 0, 1'b0, 1'b0, o);
    $display("post-rst rtype: cycles=%0d", o.cyc);
    n_vec++; if (o.cyc !== 5) begin n_err++; $display("FAIL midrst_recover: got %0d required 5", o.cyc); end
  endtask

  task automatic test_perf();
    obs_t o;
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(OP_STORE, 0, 0, 1'b0, 1'b0, o);
    $display("perf after 3 stores: cycle_cnt=%0d instret_cnt=%0d", cycle_cnt, instret_cnt);
`ifdef SEQ_PERF_CNT_EN
    n_vec++; if (instret_cnt !== 4'd3) begin n_err++; $display("FAIL perf_instret: got %0d required 3", instret_cnt); end
    n_vec++; if (cycle_cnt !== 4'd15) begin n_err++; $display("FAIL perf_cycle: got %0d required 15", cycle_cnt); end
    @(posedge clk); #1;
    n_vec++; if (cycle_cnt !== 4'd0) begin n_err++; $display("FAIL perf_wrap: got %0d required 0", cycle_cnt); end
`else
    n_vec++; if ({cycle_cnt, instret_cnt} !== 8'h00) begin
      n_err++; $display("FAIL perf_tied: got %h required 00", {cycle_cnt, instret_cnt}); end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jal_store();
    test_back_to_back();
    test_trap();
    test_rst_mid_fetch();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
